// File: rtl/step_gen_pkg.sv
// Shared definitions for the step generator family: pulse FSM encoding,
// default timing constants and direction pin polarity.
package step_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_GAP   = 2'd3
    } step_state_t;

    localparam int DEF_VEL_W      = 32;
    localparam int DEF_ACC_PERIOD = 1000;
    localparam int DEF_CNT_W      = 10;
    localparam int DEF_DIR_SETUP  = 100;
    localparam int DEF_STEP_HIGH  = 300;
    localparam int DEF_STEP_GAP   = 100;

    // dir pin level that means "moving toward negative position"
    localparam logic DIR_NEG = 1'b1;

endpackage

// File: rtl/step_pulse_fsm.sv
// Turns DDA step requests into driver pulses with dir-setup, high and gap
// timing; reports the committed position change and dropped requests.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for a step request
// ST_SETUP | dir just changed, holding off the step edge for DIR_SETUP clocks
// ST_HIGH  | step pin high for STEP_HIGH clocks
// ST_GAP   | step pin low for STEP_GAP clocks; position commits on last edge
module step_pulse_fsm
    import step_gen_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int DIR_SETUP = DEF_DIR_SETUP,
    parameter int STEP_HIGH = DEF_STEP_HIGH,
    parameter int STEP_GAP  = DEF_STEP_GAP
) (
    input  logic clk,
    input  logic reset,
    input  logic abort,
    input  logic req,
    input  logic dir_in,
    input  logic clear_overrun,
    output logic step,
    output logic dir,
    output logic pos_inc,
    output logic pos_dec,
    output logic overrun,
    output logic idle
);

    if (DIR_SETUP > (1 << CNT_W) || STEP_HIGH > (1 << CNT_W) || STEP_GAP > (1 << CNT_W)
        || STEP_HIGH < 1 || STEP_GAP < 1 || DIR_SETUP < 0) begin : g_bad_timing
        $error("step_pulse_fsm: timing parameters do not fit the CNT_W counter");
    end

    localparam logic [CNT_W-1:0] SETUP_TC = CNT_W'(DIR_SETUP - 1);
    localparam logic [CNT_W-1:0] HIGH_TC  = CNT_W'(STEP_HIGH - 1);
    localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(STEP_GAP - 1);

    step_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             step_nxt, dir_nxt, overrun_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            step    <= 1'b0;
            dir     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            step    <= step_nxt;
            dir     <= dir_nxt;
            overrun <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        step_nxt    = step;
        dir_nxt     = dir;
        overrun_nxt = overrun;
        pos_inc     = 1'b0;
        pos_dec     = 1'b0;

        if (clear_overrun)
            overrun_nxt = 1'b0;
        if (req && state != ST_IDLE)
            overrun_nxt = 1'b1;

        case (state)
            ST_IDLE: begin
                if (req) begin
                    cnt_nxt = '0;
                    dir_nxt = dir_in;
                    // a zero setup time degenerates into the same-dir path
                    if (dir_in != dir && DIR_SETUP != 0) begin
                        state_nxt = ST_SETUP;
                    end else begin
                        step_nxt  = 1'b1;
                        state_nxt = ST_HIGH;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt == SETUP_TC) begin
                    cnt_nxt   = '0;
                    step_nxt  = 1'b1;
                    state_nxt = ST_HIGH;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_HIGH: begin
                if (cnt == HIGH_TC) begin
                    cnt_nxt   = '0;
                    step_nxt  = 1'b0;
                    state_nxt = ST_GAP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_TC) begin
                    cnt_nxt   = '0;
                    pos_inc   = (dir != DIR_NEG);
                    pos_dec   = (dir == DIR_NEG);
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase

        // abort drops the pulse in flight without committing it; dir and overrun hold
        if (abort) begin
            state_nxt   = ST_IDLE;
            cnt_nxt     = '0;
            step_nxt    = 1'b0;
            dir_nxt     = dir;
            overrun_nxt = overrun;
            pos_inc     = 1'b0;
            pos_dec     = 1'b0;
        end
    end

    assign idle = (state == ST_IDLE);

endmodule

// File: rtl/step_ramp_gen.sv
// Single-axis step generator: velocity ramp toward a target, DDA phase
// accumulator, pulse timing FSM and absolute position counter.
module step_ramp_gen
    import step_gen_pkg::*;
#(
    parameter int VEL_W      = DEF_VEL_W,
    parameter int ACC_PERIOD = DEF_ACC_PERIOD,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int DIR_SETUP  = DEF_DIR_SETUP,
    parameter int STEP_HIGH  = DEF_STEP_HIGH,
    parameter int STEP_GAP   = DEF_STEP_GAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [VEL_W-1:0] velocity,
    input  logic [VEL_W-1:0] max_accel,
    input  logic [VEL_W-1:0] data_in,
    input  logic             set_position,
    input  logic             clear_overrun,
    output logic [VEL_W-1:0] position,
    output logic [VEL_W-1:0] cur_velocity,
    output logic [VEL_W-1:0] acc,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             overrun
);

    localparam int CYC_W = (ACC_PERIOD > 1) ? $clog2(ACC_PERIOD) : 1;
    localparam logic [CYC_W-1:0] CYC_TC = CYC_W'(ACC_PERIOD - 1);

    logic [CYC_W-1:0] cycle;
    logic [VEL_W-1:0] tgt, vel_nxt, acc_nxt;
    logic [VEL_W:0]   diff, diff_mag;
    logic             req, pos_inc, pos_dec, fsm_idle;

    always_comb begin
        tgt = enable ? velocity : '0;
        // one extra bit keeps the signed difference free of overflow
        diff     = {tgt[VEL_W-1], tgt} - {cur_velocity[VEL_W-1], cur_velocity};
        diff_mag = diff[VEL_W] ? (~diff + 1'b1) : diff;
        if (diff_mag <= {1'b0, max_accel})
            vel_nxt = tgt;
        else if (diff[VEL_W])
            vel_nxt = cur_velocity - max_accel;
        else
            vel_nxt = cur_velocity + max_accel;

        acc_nxt = acc + cur_velocity;
        req     = acc_nxt[VEL_W-1] ^ acc[VEL_W-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle        <= '0;
            position     <= '0;
            cur_velocity <= '0;
            acc          <= '0;
        end else if (set_position) begin
            cycle        <= '0;
            position     <= data_in;
            cur_velocity <= '0;
            acc          <= '0;
        end else begin
            acc <= acc_nxt;
            if (cycle == CYC_TC) begin
                cycle        <= '0;
                cur_velocity <= vel_nxt;
            end else begin
                cycle <= cycle + 1'b1;
            end
            if (pos_inc)
                position <= position + 1'b1;
            else if (pos_dec)
                position <= position - 1'b1;
        end
    end

    step_pulse_fsm #(
        .CNT_W     (CNT_W),
        .DIR_SETUP (DIR_SETUP),
        .STEP_HIGH (STEP_HIGH),
        .STEP_GAP  (STEP_GAP)
    ) u_pulse (
        .clk           (clk),
        .reset         (reset),
        .abort         (set_position),
        .req           (req),
        .dir_in        (cur_velocity[VEL_W-1]),
        .clear_overrun (clear_overrun),
        .step          (step),
        .dir           (dir),
        .pos_inc       (pos_inc),
        .pos_dec       (pos_dec),
        .overrun       (overrun),
        .idle          (fsm_idle)
    );

    assign busy = !fsm_idle || (cur_velocity != '0);

endmodule

// File: tb/tb_step_ramp_gen.sv
// Directed bench for step_ramp_gen: ramp, clamp/stop, pulse timing,
// reversal, overrun, set_position abort and reset.
module tb_step_ramp_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] velocity;
    logic [31:0] max_accel;
    logic [31:0] data_in;
    logic        set_position;
    logic        clear_overrun;
    logic [31:0] position;
    logic [31:0] cur_velocity;
    logic [31:0] acc;
    logic        step;
    logic        dir;
    logic        busy;
    logic        overrun;

    int n_vec = 0;
    int n_bad = 0;

    step_ramp_gen #(
        .VEL_W      (32),
        .ACC_PERIOD (1000),
        .CNT_W      (10),
        .DIR_SETUP  (4),
        .STEP_HIGH  (6),
        .STEP_GAP   (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .velocity      (velocity),
        .max_accel     (max_accel),
        .data_in       (data_in),
        .set_position  (set_position),
        .clear_overrun (clear_overrun),
        .position      (position),
        .cur_velocity  (cur_velocity),
        .acc           (acc),
        .step          (step),
        .dir           (dir),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp_v));
        end
    endtask

    // advance n rising edges, then settle 1 time unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // after this, the next rising edge is edge 1
    task automatic do_reset(input logic [31:0] vel, input logic [31:0] acl);
        reset = 1'b1;
        velocity = vel;
        max_accel = acl;
        enable = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pos"}, position, 0);
        chk({tag, "_vel"}, cur_velocity, 0);
        chk({tag, "_acc"}, acc, 0);
        chk({tag, "_step"}, 32'(step), 0);
        chk({tag, "_dir"}, 32'(dir), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ovr"}, 32'(overrun), 0);
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        velocity = '0;
        max_accel = '0;
        data_in = '0;
        set_position = 1'b0;
        clear_overrun = 1'b0;

        // 1: ramp up in steps of 200
        do_reset(32'd1000, 32'd200);
        chk_all_zero("rst");
        tick(999);
        chk("ramp_pre", cur_velocity, 0);
        tick(1);
        chk("ramp_1000", cur_velocity, 200);
        chk("acc_1000", acc, 0);
        tick(1000);
        chk("ramp_2000", cur_velocity, 400);
        chk("acc_2000", acc, 200000);
        for (int k = 3; k <= 5; k++) begin
            tick(1000);
            chk("ramp_k", cur_velocity, 32'(200 * k));
        end
        tick(1000);
        chk("ramp_hold", cur_velocity, 1000);

        // 2: clamp to a small negative target, then controlled stop
        do_reset(-32'sd150, 32'd200);
        tick(1000);
        chk("clamp_1000", cur_velocity, -32'sd150);
        enable = 1'b0;
        tick(999);
        chk("stop_busy_pre", 32'(busy), 1);
        tick(1);
        chk("stop_2000", cur_velocity, 0);
        chk("stop_busy", 32'(busy), 0);
        chk("stop_pos", position, -32'sd1);
        chk("stop_dir", 32'(dir), 1);

        // 3: same-direction step timing, one request per 32 clocks
        do_reset(32'h0400_0000, 32'h4000_0000);
        tick(1000);
        chk("t3_vel", cur_velocity, 32'h0400_0000);
        tick(31);
        chk("t3_step_1031", 32'(step), 0);
        tick(1);
        chk("t3_step_1032", 32'(step), 1);
        chk("t3_dir", 32'(dir), 0);
        tick(5);
        chk("t3_step_1037", 32'(step), 1);
        tick(1);
        chk("t3_step_1038", 32'(step), 0);
        tick(3);
        chk("t3_pos_1041", position, 0);
        tick(1);
        chk("t3_pos_1042", position, 1);
        chk("t3_busy", 32'(busy), 1);
        tick(22);
        chk("t3_step_1064", 32'(step), 1);
        tick(10);
        chk("t3_pos_1074", position, 2);
        chk("t3_ovr", 32'(overrun), 0);

        // 4: reversal at the edge-2000 ramp update
        velocity = -32'sh0400_0000;
        tick(934);
        chk("t4_dir_2008", 32'(dir), 0);
        chk("t4_pos_2008", position, 31);
        tick(1);
        chk("t4_dir_2009", 32'(dir), 1);
        chk("t4_step_2009", 32'(step), 0);
        tick(3);
        chk("t4_step_2012", 32'(step), 0);
        tick(1);
        chk("t4_step_2013", 32'(step), 1);
        tick(5);
        chk("t4_step_2018", 32'(step), 1);
        chk("t4_dir_2018", 32'(dir), 1);
        tick(1);
        chk("t4_step_2019", 32'(step), 0);
        tick(3);
        chk("t4_pos_2022", position, 31);
        chk("t4_dir_2022", 32'(dir), 1);
        tick(1);
        chk("t4_pos_2023", position, 30);

        // 5: request every 8 clocks against a 10-clock minimum period
        do_reset(32'h1000_0000, 32'h4000_0000);
        tick(1015);
        chk("t5_ovr_1015", 32'(overrun), 0);
        tick(1);
        chk("t5_ovr_1016", 32'(overrun), 1);
        chk("t5_step_1016", 32'(step), 0);
        tick(8);
        chk("t5_step_1024", 32'(step), 1);
        tick(1);
        clear_overrun = 1'b1;
        tick(1);
        clear_overrun = 1'b0;
        chk("t5_clr", 32'(overrun), 0);
        tick(5);
        clear_overrun = 1'b1;
        tick(1);
        clear_overrun = 1'b0;
        chk("t5_clr_vs_drop", 32'(overrun), 1);
        chk("t5_step_1032", 32'(step), 0);
        chk("t5_pos_1032", position, 1);

        // 6: set_position while step is high (step at 1040)
        tick(9);
        chk("t6_step_1041", 32'(step), 1);
        data_in = 32'd1234;
        set_position = 1'b1;
        tick(1);
        set_position = 1'b0;
        chk("t6_pos", position, 1234);
        chk("t6_step", 32'(step), 0);
        chk("t6_acc", acc, 0);
        chk("t6_vel", cur_velocity, 0);
        chk("t6_ovr_held", 32'(overrun), 1);
        tick(10);
        chk("t6_pos_nocommit", position, 1234);
        tick(990);
        chk("t6_vel_2042", cur_velocity, 32'h1000_0000);
        tick(16);
        chk("t6_step_gap", 32'(step), 0);
        chk("t6_busy_gap", 32'(busy), 1);
        chk("t6_pos_gap", position, 1234);
        reset = 1'b1;
        tick(1);
        chk_all_zero("gap_rst");
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
